// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter in front of the register file write port.
//               Merges a single-cycle ALU result path and a FIFO-buffered
//               load-return path onto one registered write port
//               (we/waddr/wbdata). The ALU has fixed priority unless the
//               load FIFO is full or its head has waited STARVE_LIMIT cycles,
//               in which case the load head is forced through.
// Ports       : clk, reset (sync, active-low)
//               alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//               ld_valid/ld_ready/ld_rd/ld_data     : load-return handshake
//               we/waddr/wbdata                     : registered write port
//               bad_addr                            : dropped out-of-range write
//               ld_count                            : load FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NUM_REGS     = 10,
    parameter int LD_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wbdata,
    output logic        bad_addr,
    output logic [2:0]  ld_count
);

    localparam int                    c_ptr_w    = $clog2(LD_DEPTH);
    localparam int                    c_wait_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [2:0]            c_depth    = 3'(LD_DEPTH);
    localparam logic [c_wait_w-1:0]   c_starve   = c_wait_w'(STARVE_LIMIT);
    // One extra bit so a NUM_REGS of 32 still compares correctly.
    localparam logic [5:0]            c_num_regs = 6'(NUM_REGS);

    // Load FIFO storage and control
    logic [4:0]          r_mem_rd   [LD_DEPTH];
    logic [31:0]         r_mem_data [LD_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [2:0]          r_count;
    logic [c_wait_w-1:0] r_wait;

    // Registered write port
    logic                r_we;
    logic [4:0]          r_waddr;
    logic [31:0]         r_wbdata;
    logic                r_bad;

    logic                w_empty;
    logic                w_full;
    logic                w_force;
    logic                w_push;
    logic                w_pop;
    logic                w_alu_grant;
    logic                w_grant;
    logic [4:0]          w_grant_rd;
    logic [31:0]         w_grant_data;
    logic                w_rd_ok;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == c_depth);

    // The load head takes the port when the FIFO cannot accept more or the
    // head has been passed over long enough.
    assign w_force = !w_empty && (w_full || (r_wait >= c_starve));

    // Ready signals are gated by reset so nothing is accepted during reset.
    // ld_ready ignores a same-cycle pop: a full FIFO never accepts.
    assign alu_ready = reset && !w_force;
    assign ld_ready  = reset && !w_full;

    assign w_push      = ld_valid && ld_ready;
    assign w_alu_grant = alu_valid && alu_ready;
    assign w_pop       = reset && !w_alu_grant && !w_empty;
    assign w_grant     = w_alu_grant || w_pop;

    assign w_grant_rd   = w_alu_grant ? alu_rd   : r_mem_rd[r_rd_ptr];
    assign w_grant_data = w_alu_grant ? alu_data : r_mem_data[r_rd_ptr];
    assign w_rd_ok      = ({1'b0, w_grant_rd} < c_num_regs);

    // FIFO storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ld_rd;
            r_mem_data[r_wr_ptr] <= ld_data;
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 3'd0;
            r_wait   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            // Counts cycles the current head has been passed over; a new
            // head starts from zero because the pop clears it.
            if (w_empty || w_pop) begin
                r_wait <= '0;
            end else if (r_wait < c_starve) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end
    end

    // Write port register: address/data hold when idle, strobes drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_waddr  <= 5'd0;
            r_wbdata <= 32'd0;
            r_bad    <= 1'b0;
        end else if (w_grant) begin
            r_we     <= w_rd_ok;
            r_bad    <= !w_rd_ok;
            r_waddr  <= w_grant_rd;
            r_wbdata <= w_grant_data;
        end else begin
            r_we     <= 1'b0;
            r_bad    <= 1'b0;
        end
    end

    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wbdata   = r_wbdata;
    assign bad_addr = r_bad;
    assign ld_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A table of directed
//               vectors, hand-written multi-cycle sequences (starvation,
//               full FIFO, reset mid-operation) and a randomized phase, all
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int NREGS = 10;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wbdata;
    logic        bad_addr;
    logic [2:0]  ld_count;

    wb_arbiter #(
        .NUM_REGS    (NREGS),
        .LD_DEPTH    (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .we       (we),
        .waddr    (waddr),
        .wbdata   (wbdata),
        .bad_addr (bad_addr),
        .ld_count (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: load FIFO as a queue plus the expected write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_wait;
    logic        m_we;
    logic        m_bad;
    logic [4:0]  m_waddr;
    logic [31:0] m_wbdata;

    // Outputs sampled mid-cycle by the last step
    logic        s_ar, s_lr, s_we, s_bad;
    logic [2:0]  s_cnt;
    logic [4:0]  s_waddr;
    logic [31:0] s_wbdata;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample and
    // compare against the model, then advance the model past the next
    // rising edge.
    task automatic step(input logic r, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ldd, input string tag);
        logic   e_ar, e_lr, full, frc, popped, was_empty;
        ent_t   g;
        logic   granted;
        @(negedge clk);
        reset     = r;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldd;
        #1;
        s_ar = alu_ready; s_lr = ld_ready; s_cnt = ld_count; s_we = we;
        s_waddr = waddr; s_wbdata = wbdata; s_bad = bad_addr;

        full = (mq.size() == DEPTH);
        frc  = (mq.size() > 0) && (full || m_wait >= LIMIT);
        e_ar = r && !frc;
        e_lr = r && !full;
        chk({"model ", tag},
            {20'd0, s_ar, s_lr, s_cnt, s_we, s_waddr, s_wbdata, s_bad},
            {20'd0, e_ar, e_lr, 3'(mq.size()), m_we, m_waddr, m_wbdata, m_bad});

        if (!r) begin
            mq.delete();
            m_wait = 0; m_we = 0; m_bad = 0; m_waddr = 0; m_wbdata = 0;
        end else begin
            was_empty = (mq.size() == 0);
            popped    = 0;
            granted   = 0;
            if (av && e_ar) begin
                g.rd = ard; g.data = ad; granted = 1;
            end else if (!was_empty) begin
                g = mq.pop_front(); granted = 1; popped = 1;
            end
            if (was_empty || popped) m_wait = 0;
            else if (m_wait < LIMIT) m_wait++;
            if (lv && e_lr) begin
                ent_t n;
                n.rd = lrd; n.data = ldd;
                mq.push_back(n);
            end
            if (granted) begin
                m_we     = (int'(g.rd) < NREGS);
                m_bad    = (int'(g.rd) >= NREGS);
                m_waddr  = g.rd;
                m_wbdata = g.data;
            end else begin
                m_we  = 0;
                m_bad = 0;
            end
        end
    endtask

    typedef struct {
        logic        rst, av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_ar, e_lr;
        logic [2:0]  e_cnt;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wbdata;
        logic        e_bad;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [4:0] seen[$];
        logic       ok;

        // Directed table: expected outputs are those visible in the same
        // cycle the inputs are applied (write port reflects last cycle).
        tbl[0]  = '{1'b0, 1'b1, 5'd3,  32'h1,        1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0,  32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd3,  32'h1,        1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0,  32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0,  32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 5'd12, 32'h55,       1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd12, 32'h55,       1'b1};
        tbl[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd12, 32'h55,       1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd0,  32'hA5A5,     1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd12, 32'h55,       1'b0};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd0,  32'hA5A5,     1'b0};
        tbl[10] = '{1'b1, 1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0,  32'hA5A5,     1'b0};
        tbl[11] = '{1'b1, 1'b1, 5'd10, 32'h1010,     1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd9,  32'h99,       1'b0};
        tbl[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd10, 32'h1010,     1'b1};
        tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd10, 32'h1010,     1'b0};

        reset = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        m_wait = 0; m_we = 0; m_bad = 0; m_waddr = 0; m_wbdata = 0;
        @(posedge clk);   // registers leave their power-up state here

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad,
                 tbl[i].lv, tbl[i].lrd, tbl[i].ld, $sformatf("row%0d", i));
            chk($sformatf("table row%0d", i),
                {20'd0, s_ar, s_lr, s_cnt, s_we, s_waddr, s_wbdata, s_bad},
                {20'd0, tbl[i].e_ar, tbl[i].e_lr, tbl[i].e_cnt, tbl[i].e_we,
                 tbl[i].e_waddr, tbl[i].e_wbdata, tbl[i].e_bad});
        end

        // Starvation: ALU wins three cycles, then the load is forced.
        step(1, 1, 5'd1, 32'h100, 1, 5'd5, 32'h11, "starve push");
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 5'd1, 32'h101 + 32'(i), 0, 5'd0, 32'h0, "starve wait");
            chk($sformatf("starve alu_ready c%0d", i), 64'(s_ar), (i < 3) ? 64'd1 : 64'd0);
        end
        step(1, 1, 5'd1, 32'h105, 0, 5'd0, 32'h0, "starve write");
        chk("starve load write", {27'd0, s_we, s_ar, s_waddr, s_wbdata},
            {27'd0, 1'b1, 1'b1, 5'd5, 32'h11});
        step(1, 1, 5'd1, 32'h106, 0, 5'd0, 32'h0, "starve resume");
        chk("starve alu resumes", {27'd0, s_we, 5'd0, s_waddr, s_wbdata},
            {27'd0, 1'b1, 5'd0, 5'd1, 32'h105});
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "idle");

        // Full FIFO: four loads back-to-back under constant ALU traffic.
        for (int i = 0; i < 4; i++)
            step(1, 1, 5'd1, 32'h200 + 32'(i), 1, 5'd6 + 5'(i), 32'h60 + 32'(i), "full push");
        step(1, 1, 5'd1, 32'h210, 0, 5'd0, 32'h0, "full pop");
        chk("full state", {59'd0, s_cnt, s_lr, s_ar}, {59'd0, 3'd4, 1'b0, 1'b0});
        step(1, 1, 5'd1, 32'h211, 0, 5'd0, 32'h0, "full after pop");
        chk("full first drain", {20'd0, s_lr, s_cnt, s_we, s_waddr, s_wbdata},
            {20'd0, 1'b1, 3'd3, 1'b1, 5'd6, 32'h60});
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 5'd1, 32'h220 + 32'(i), 0, 5'd0, 32'h0, "full drain");
            if (s_we && s_waddr >= 5'd6) seen.push_back(s_waddr);
        end
        ok = (seen.size() == 3);
        for (int i = 0; i < seen.size() && ok; i++)
            if (seen[i] != 5'd7 + 5'(i)) ok = 0;
        chk("full drain order", 64'(ok), 64'd1);
        chk("full drained count", 64'(s_cnt), 64'd0);

        // Reset mid-operation discards queued loads.
        for (int i = 0; i < 3; i++)
            step(1, 1, 5'd1, 32'h300, 1, 5'd2 + 5'(2 * i), 32'h70 + 32'(i), "rst push");
        step(0, 1, 5'd1, 32'h301, 0, 5'd0, 32'h0, "rst mid");
        chk("rst queued count", 64'(s_cnt), 64'd3);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "rst release");
        chk("rst cleared", {58'd0, s_cnt, s_we, s_bad, s_lr}, {58'd0, 3'd0, 1'b0, 1'b0, 1'b1});
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, "rst idle");
            if (s_we) ok = 0;
        end
        chk("rst no stale writes", 64'(ok), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 15)), $urandom,
                 $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 10-entry register file write port (we/waddr/wbdata).
- Merges results from two producers onto the single write port:
  - single-cycle ALU result path;
  - load-return path, buffered in a small FIFO.
- Uses fixed ALU priority with load-starvation and FIFO-full overrides.
- Registers the write port, so the regfile sees a clean one-cycle-late write.

Parameters:
- NUM_REGS, 10, number of architectural registers; writes with rd >= NUM_REGS are suppressed.
- LD_DEPTH, 4, load-return FIFO depth (power of two, >= 2).
- STARVE_LIMIT, 3, consecutive cycles a load head may wait before it forces priority.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-low reset
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- ld_valid  input  1  load return valid
- ld_ready  output  1  load FIFO can accept
- ld_rd  input  5  load destination register
- ld_data  input  32  load data
- we  output  1  regfile write enable (registered)
- waddr  output  5  regfile write address (registered)
- wbdata  output  32  regfile write data (registered)
- bad_addr  output  1  one-cycle pulse: accepted result had rd >= NUM_REGS and was dropped
- ld_count  output  3  current load FIFO occupancy (0..LD_DEPTH)

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO empty, ld_count=0, wait_cnt=0.
  - we=0, waddr=0, wbdata=0, bad_addr=0.
  - While reset is low, alu_ready=0 and ld_ready=0 (combinational on reset).
  - Reset mid-operation discards all FIFO contents and any in-flight result.
- Load FIFO:
  - ld_ready = !full.
  - Push on ld_valid && ld_ready.
  - No same-cycle pass-through when full: ld_ready stays 0 when full even if a pop occurs.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - Order preserved; pointers wrap modulo LD_DEPTH.
- Force condition: force = !empty && (full || wait_cnt >= STARVE_LIMIT).
- alu_ready:
  - alu_ready = reset && !force.
  - Must not depend on alu_valid.
- Grant per cycle:
  - alu_valid && alu_ready -> ALU granted.
  - Else if !empty -> FIFO head granted and popped.
  - Else no grant.
  - Exactly one grant max per cycle.
- wait_cnt:
  - Cleared when the FIFO is empty or the head is popped.
  - Otherwise increments each cycle the head is non-empty and not granted.
  - Saturates at STARVE_LIMIT.
- Output register, updated at the posedge after a grant:
  - waddr <= granted rd; wbdata <= granted data.
  - we <= (rd < NUM_REGS).
  - bad_addr <= (rd >= NUM_REGS).
  - No grant: we=0, bad_addr=0, waddr/wbdata hold their last values.
- Latency: a result accepted in cycle N appears on we/waddr/wbdata in cycle N+1. A load that waits k cycles in the FIFO appears k+1 cycles after push.
- rd==0 is a normal writable register; no hardwiring.
- Throughput: one write per cycle sustained.

Test Plan:
- Reset: hold reset=0 for 2 cycles with alu_valid=1, ld_valid=1 -> alu_ready=0, ld_ready=0, we=0, waddr=0, wbdata=0, ld_count=0. Release reset -> first write appears the following cycle.
- ALU only: alu_valid=1, rd=3, data=0xDEADBEEF for 1 cycle -> next cycle we=1, waddr=3, wbdata=0xDEADBEEF; cycle after, we=0 and waddr/wbdata hold.
- Starvation: push one load (rd=5, data=0x11) while alu_valid is held 1 continuously (rd=1, data incrementing) -> ALU wins 3 cycles, then alu_ready=0 for 1 cycle and the load is written (waddr=5, wbdata=0x11), then ALU resumes.
- Full FIFO: alu_valid=1 constantly, push 4 loads (rd 6,7,8,9) back-to-back -> ld_ready=0 at ld_count=4. Force pops drain the loads in order 6,7,8,9, and ld_ready returns to 1 one cycle after the first pop.
- Bad address: ALU rd=12, data=0x55 -> alu_ready handshake completes, next cycle we=0, bad_addr=1 for exactly 1 cycle, waddr=12.
- Reset mid-operation: 3 loads queued, reset=0 for one cycle -> ld_count=0, no subsequent writes of the queued loads after release.
